// File: rtl/ball_motion_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ball_motion_engine
//  Purpose  : Holds the Breakout ball position and steps it at a fixed rate,
//             strobing the collision engine for a new direction before each
//             step.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_motion_engine #(
    parameter int STEP_DIV = 400000,
    parameter int STEP     = 1,
    parameter int START_X  = 304,
    parameter int START_Y  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       launch,
    input  logic [1:0] direction,
    input  logic       lock,
    output logic [9:0] ballXPos,
    output logic [9:0] ballYPos,
    output logic       ballDirUpdate,
    output logic       ballLost
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_LOST   = 3'd4;

    localparam logic [19:0] c_TERM  = 20'(STEP_DIV - 1);
    localparam logic [10:0] c_STEP  = 11'(STEP);
    localparam logic [10:0] c_MAX   = 11'd1023;
    localparam logic [9:0]  c_START_X = 10'(START_X);
    localparam logic [9:0]  c_START_Y = 10'(START_Y);

    logic [2:0]  r_state;
    logic [19:0] r_count;
    logic [9:0]  r_x;
    logic [9:0]  r_y;

    // One axis step in 11 bits so both edges of the field clamp instead of wrapping.
    function automatic logic [9:0] f_move(input logic [9:0] pos, input logic dec);
        logic [10:0] ext;
        logic [10:0] sum;
        ext = {1'b0, pos};
        sum = ext + c_STEP;
        if (dec)
            f_move = (ext < c_STEP) ? 10'd0 : 10'(ext - c_STEP);
        else
            f_move = (sum > c_MAX) ? 10'd1023 : 10'(sum);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_x     <= c_START_X;
            r_y     <= c_START_Y;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (launch) begin
                        r_state <= S_RUN;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    // A lost ball beats the terminal count, so no strobe escapes.
                    if (lock) begin
                        r_state <= S_LOST;
                    end else if (r_count == c_TERM) begin
                        r_state <= S_STROBE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 20'd1;
                    end
                end
                S_STROBE: r_state <= S_STEP;
                S_STEP: begin
                    if (lock) begin
                        r_state <= S_LOST;
                    end else begin
                        r_x     <= f_move(r_x, direction[0]);
                        r_y     <= f_move(r_y, direction[1]);
                        r_state <= S_RUN;
                    end
                end
                S_LOST: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ballXPos      = r_x;
    assign ballYPos      = r_y;
    assign ballDirUpdate = (r_state == S_STROBE);
    assign ballLost      = (r_state == S_LOST);

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ball_motion_engine
//  Purpose  : Directed bench with a cycle-timeline reference model for
//             ball_motion_engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int SX = 300;
    localparam int SY = 200;

    logic       clk = 1'b0;
    logic       rst, enable, launch, lock;
    logic [1:0] direction;
    logic [9:0] ballXPos, ballYPos;
    logic       ballDirUpdate, ballLost;

    logic       launch2;
    logic [1:0] dir2;
    logic [9:0] x2, y2;
    logic       upd2, lost2;

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 0;

    always #5 clk = ~clk;

    ball_motion_engine #(.STEP_DIV(D), .STEP(S), .START_X(SX), .START_Y(SY)) dut (
        .clk(clk), .rst(rst), .enable(enable), .launch(launch),
        .direction(direction), .lock(lock),
        .ballXPos(ballXPos), .ballYPos(ballYPos),
        .ballDirUpdate(ballDirUpdate), .ballLost(ballLost)
    );

    ball_motion_engine #(.STEP_DIV(D), .STEP(S), .START_X(1), .START_Y(1023)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .launch(launch2),
        .direction(dir2), .lock(1'b0),
        .ballXPos(x2), .ballYPos(y2),
        .ballDirUpdate(upd2), .ballLost(lost2)
    );

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: where the ball is within its D+2 cycle period, in enabled cycles.
    bit mIdle = 1, mLost = 0;
    int mTick = 0, mX = SX, mY = SY;

    function automatic int clampMove(input int p, input bit dec);
        int n;
        n = dec ? p - S : p + S;
        if (n < 0) n = 0;
        if (n > 1023) n = 1023;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mIdle = 1; mLost = 0; mTick = 0; mX = SX; mY = SY;
        end else if (enable && !mLost) begin
            if (mIdle) begin
                if (launch) begin mIdle = 0; mTick = 0; end
            end else if (mTick < D) begin
                if (lock) mLost = 1; else mTick++;
            end else if (mTick == D) begin
                mTick++;
            end else begin
                if (lock) mLost = 1;
                else begin
                    mX = clampMove(mX, direction[0]);
                    mY = clampMove(mY, direction[1]);
                end
                mTick = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            chk("model X", int'(ballXPos), mX);
            chk("model Y", int'(ballYPos), mY);
            chk("model strobe", int'(ballDirUpdate), int'(!mIdle && !mLost && mTick == D));
            chk("model lost", int'(ballLost), int'(mLost));
        end
    end

    task automatic waitStrobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ballDirUpdate && n < 50);
        if (!ballDirUpdate) chk("strobe wait timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, strobes;
        rst = 1; enable = 1; launch = 0; lock = 0; direction = 2'b10;
        launch2 = 0; dir2 = 2'b01;
        repeat (3) @(negedge clk);
        rst = 0;
        checkOn = 1;

        // Idle hold
        repeat (50) @(negedge clk);
        chk("idle X", int'(ballXPos), 300);
        chk("idle Y", int'(ballYPos), 200);
        chk("idle lost", int'(ballLost), 0);

        // Launch north-east
        launch = 1;
        waitStrobe(n);
        chk("first strobe latency", n, 5);
        chk("X during strobe", int'(ballXPos), 300);
        @(negedge clk);
        chk("Y during step", int'(ballYPos), 200);
        @(negedge clk);
        chk("step1 X", int'(ballXPos), 302);
        chk("step1 Y", int'(ballYPos), 198);
        repeat (6) @(negedge clk);
        chk("step2 X", int'(ballXPos), 304);
        chk("step2 Y", int'(ballYPos), 196);

        // Direction changes on the strobe edge
        rst = 1; @(negedge clk); rst = 0;
        direction = 2'b10;
        waitStrobe(n);
        direction = 2'b00;
        repeat (2) @(negedge clk);
        chk("flip X", int'(ballXPos), 302);
        chk("flip Y", int'(ballYPos), 202);

        // Reset landing in the middle of a strobe
        waitStrobe(n);
        rst = 1; launch = 0;
        @(negedge clk);
        rst = 0;
        chk("rst-in-strobe strobe", int'(ballDirUpdate), 0);
        chk("rst-in-strobe X", int'(ballXPos), 300);

        // Freeze mid-RUN
        direction = 2'b10; launch = 1;
        waitStrobe(n);
        repeat (2) @(negedge clk);
        chk("pre-freeze X", int'(ballXPos), 302);
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        enable = 0;
        strobes = 0;
        repeat (10) begin @(negedge clk); n++; strobes += int'(ballDirUpdate); end
        enable = 1;
        while (ballXPos == 10'd302 && n < 100) begin @(negedge clk); n++; end
        chk("freeze period", n, 16);
        chk("freeze strobes", strobes, 0);
        chk("post-freeze Y", int'(ballYPos), 196);

        // Lost during RUN
        lock = 1;
        @(negedge clk);
        lock = 0;
        chk("lost flag", int'(ballLost), 1);
        direction = 2'b11;
        strobes = 0;
        repeat (20) begin @(negedge clk); strobes += int'(ballDirUpdate); end
        chk("lost strobes", strobes, 0);
        chk("lost X frozen", int'(ballXPos), 304);
        chk("lost Y frozen", int'(ballYPos), 196);
        rst = 1; launch = 0;
        @(negedge clk);
        rst = 0;
        chk("post-lost X", int'(ballXPos), 300);
        chk("post-lost Y", int'(ballYPos), 200);
        chk("post-lost flag", int'(ballLost), 0);

        // Saturation at both field edges
        launch2 = 1;
        repeat (5) @(negedge clk);
        chk("sat strobe", int'(upd2), 1);
        repeat (2) @(negedge clk);
        chk("sat X step1", int'(x2), 0);
        chk("sat Y step1", int'(y2), 1023);
        repeat (6) @(negedge clk);
        chk("sat X step2", int'(x2), 0);
        chk("sat Y step2", int'(y2), 1023);
        repeat (6) @(negedge clk);
        chk("sat X step3", int'(x2), 0);
        chk("sat Y step3", int'(y2), 1023);
        chk("sat lost", int'(lost2), 0);

        checkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
